// File: rtl/bridge_ctrl_pkg.sv
// Shared types and pattern constants for the bridge controller.
// Patterns are ordered {top, bot, plus, minus, pause_p, pause_n}.
package bridge_ctrl_pkg;

   typedef enum logic [2:0] {
      CMD_OFF   = 3'd0,
      CMD_PLUS  = 3'd1,
      CMD_MINUS = 3'd2,
      CMD_BAL_P = 3'd3,
      CMD_BAL_N = 3'd4,
      CMD_START = 3'd5,
      CMD_SHUT  = 3'd6,
      CMD_DIS   = 3'd7
   } cmd_t;

   typedef enum logic [3:0] {
      RX_IDLE, RX_START, RX_DIS0, RX_DIS1, RX_DIS2, RX_DIS3,
      RX_UPDATE, RX_ERROR, RX_CLR1, RX_CLR2
   } rx_state_t;

   typedef enum logic [1:0] {
      ST_IDLE, ST_WAIT_PRE, ST_WAIT_SET
   } start_state_t;

   typedef struct packed {
      logic [3:0] top;
      logic [3:0] bot;
      logic       plus;
      logic       minus;
      logic       pause_p;
      logic       pause_n;
   } pattern_t;

   localparam int PAT_W = $bits(pattern_t);

   localparam pattern_t PAT_OFF   = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam pattern_t PAT_PLUS  = '{4'b0001, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam pattern_t PAT_MINUS = '{4'b0010, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam pattern_t PAT_BAL_P = '{4'b0100, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam pattern_t PAT_BAL_N = '{4'b1000, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam pattern_t PAT_DIS3  = '{4'b0100, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0};

   function automatic pattern_t cmd_pattern(input cmd_t c);
      case (c)
         CMD_PLUS:  return PAT_PLUS;
         CMD_MINUS: return PAT_MINUS;
         CMD_BAL_P: return PAT_BAL_P;
         CMD_BAL_N: return PAT_BAL_N;
         default:   return PAT_OFF;
      endcase
   endfunction

endpackage

// File: rtl/bridge_deadtime.sv
// Dead-time holder: captures the pending pattern on load and counts the
// all-off interval down; ready is high once the interval has elapsed.
module bridge_deadtime
   import bridge_ctrl_pkg::*;
#(
   parameter int DEADTIME = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [PAT_W-1:0] pat_in,
   output logic [PAT_W-1:0] pat_pend,
   output logic             ready
);

   localparam int DT_W = $clog2(DEADTIME) + 1;

   logic [DT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg  <= '0;
         pat_pend <= '0;
      end else if (load) begin
         cnt_reg  <= DT_W'(DEADTIME);
         pat_pend <= pat_in;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - DT_W'(1);
      end
   end

   assign ready = (cnt_reg == '0);

endmodule

// File: rtl/bridge_ctrl.sv
// H-bridge command decoder with start sequencing, dead-time and sticky errors.
// Optional pattern watchdog enabled by defining BRIDGE_CTRL_WATCHDOG_EN.
module bridge_ctrl
   import bridge_ctrl_pkg::*;
#(
   parameter int FREQ       = 50000000,
   parameter int N_ERR      = 8,
   parameter int DEADTIME   = 4,
   parameter int T_PRECHG_S = 15,
   parameter int T_SETTLE_S = 1,
   parameter int FRAME_TO   = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bus_clk,
   input  logic [2:0]       bus,
   input  logic [N_ERR-1:0] err_i,
   output logic [3:0]       top,
   output logic [3:0]       bot,
   output logic             plus,
   output logic             minus,
   output logic             pause_p,
   output logic             pause_n,
   output logic             st,
   output logic             ch,
   output logic             fan,
   output logic             brk,
   output logic [N_ERR-1:0] err_flags,
   output logic             in_error,
   output logic             idle
);

   localparam int PRE_LOAD  = FREQ * T_PRECHG_S - 1;
   localparam int SET_LOAD  = FREQ * T_SETTLE_S - 1;
   localparam int START_MAX = (PRE_LOAD > SET_LOAD) ? PRE_LOAD : SET_LOAD;
   localparam int START_W   = $clog2(START_MAX) + 1;
   localparam int FRAME_W   = $clog2(FRAME_TO) + 1;

   logic                bus_clk_q;
   logic                strobe;
   cmd_t                sym;
   pattern_t            pat_reg;
   rx_state_t           rx_state;
   start_state_t        start_state;
   logic [START_W-1:0]  start_cnt;
   logic [FRAME_W-1:0]  frame_cnt;
   logic                st_reg, ch_reg, fan_reg, brk_reg, in_error_reg, idle_reg;
   logic [N_ERR-1:0]    flags_reg;
   logic                load_req;
   pattern_t            load_pat;
   logic [PAT_W-1:0]    dt_pend;
   logic                dt_ready;
   logic                wd_expire;

   assign strobe = bus_clk_q & ~bus_clk;
   assign sym    = cmd_t'(bus);

`ifdef BRIDGE_CTRL_WATCHDOG_EN
   localparam int WD_LOAD = FREQ / 10;
   localparam int WD_W    = $clog2(WD_LOAD) + 1;
   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wd_cnt <= '0;
      else if (strobe)
         wd_cnt <= WD_W'(WD_LOAD);
      else if (wd_cnt != '0)
         wd_cnt <= wd_cnt - WD_W'(1);
   end

   assign wd_expire = (|{pat_reg.top, pat_reg.bot}) && !strobe && (wd_cnt == '0);
`else
   assign wd_expire = 1'b0;
`endif

   // Pattern loads are decided here so the dead-time block latches them in the same cycle.
   always_comb begin
      load_req = 1'b0;
      load_pat = PAT_OFF;
      if (strobe && (err_i == '0) && !wd_expire) begin
         if (rx_state == RX_IDLE && sym >= CMD_PLUS && sym <= CMD_BAL_N &&
             start_state == ST_IDLE && st_reg && !ch_reg) begin
            load_req = 1'b1;
            load_pat = cmd_pattern(sym);
         end else if (rx_state == RX_DIS3 && !st_reg && !ch_reg &&
                      (sym == CMD_PLUS || sym == CMD_BAL_P)) begin
            load_req = 1'b1;
            load_pat = (sym == CMD_PLUS) ? PAT_PLUS : PAT_DIS3;
         end
      end
   end

   bridge_deadtime #(.DEADTIME(DEADTIME)) u_deadtime (
      .clk      (clk),
      .rst      (rst),
      .load     (load_req),
      .pat_in   (load_pat),
      .pat_pend (dt_pend),
      .ready    (dt_ready)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_clk_q    <= 1'b0;
         pat_reg      <= PAT_OFF;
         rx_state     <= RX_IDLE;
         start_state  <= ST_IDLE;
         start_cnt    <= '0;
         frame_cnt    <= '0;
         st_reg       <= 1'b0;
         ch_reg       <= 1'b0;
         fan_reg      <= 1'b0;
         brk_reg      <= 1'b0;
         flags_reg    <= '0;
         in_error_reg <= 1'b0;
         idle_reg     <= 1'b0;
      end else begin
         bus_clk_q    <= bus_clk;
         in_error_reg <= (rx_state == RX_ERROR);
         idle_reg     <= (rx_state == RX_IDLE);

         if (strobe)
            frame_cnt <= FRAME_W'(FRAME_TO);
         else if (frame_cnt != '0)
            frame_cnt <= frame_cnt - FRAME_W'(1);

         case (start_state)
            ST_WAIT_PRE:
               if (start_cnt == '0) begin
                  st_reg      <= 1'b1;
                  start_cnt   <= START_W'(SET_LOAD);
                  start_state <= ST_WAIT_SET;
               end else
                  start_cnt <= start_cnt - START_W'(1);
            ST_WAIT_SET:
               if (start_cnt == '0) begin
                  ch_reg      <= 1'b0;
                  start_state <= ST_IDLE;
               end else
                  start_cnt <= start_cnt - START_W'(1);
            default: ;
         endcase

         // Errors win over everything below, including the start sequencer above.
         if (err_i != '0) begin
            flags_reg   <= flags_reg | err_i;
            pat_reg     <= PAT_OFF;
            st_reg      <= 1'b0;
            ch_reg      <= 1'b0;
            fan_reg     <= 1'b1;
            brk_reg     <= 1'b1;
            start_state <= ST_IDLE;
            rx_state    <= RX_ERROR;
         end else if (wd_expire) begin
            pat_reg  <= PAT_OFF;
            rx_state <= RX_IDLE;
         end else begin
            case (rx_state)
               RX_IDLE:
                  if (strobe) begin
                     case (sym)
                        CMD_OFF:   pat_reg <= PAT_OFF;
                        CMD_START: rx_state <= RX_START;
                        CMD_DIS:   rx_state <= RX_DIS0;
                        CMD_SHUT: begin
                           pat_reg     <= PAT_OFF;
                           st_reg      <= 1'b0;
                           ch_reg      <= 1'b0;
                           fan_reg     <= 1'b0;
                           start_state <= ST_IDLE;
                        end
                        default:
                           if (load_req) begin
                              pat_reg  <= PAT_OFF;
                              rx_state <= RX_UPDATE;
                           end
                     endcase
                  end
               RX_START:
                  if (strobe) begin
                     if (sym == CMD_OFF) begin
                        pat_reg     <= PAT_OFF;
                        fan_reg     <= 1'b1;
                        st_reg      <= 1'b0;
                        ch_reg      <= 1'b1;
                        start_cnt   <= START_W'(PRE_LOAD);
                        start_state <= ST_WAIT_PRE;
                     end
                     rx_state <= RX_IDLE;
                  end else if (frame_cnt == '0)
                     rx_state <= RX_IDLE;
               RX_DIS0:
                  if (strobe) rx_state <= (sym == CMD_OFF) ? RX_DIS1 : RX_IDLE;
                  else if (frame_cnt == '0) rx_state <= RX_IDLE;
               RX_DIS1:
                  if (strobe) rx_state <= (sym == CMD_DIS) ? RX_DIS2 : RX_IDLE;
                  else if (frame_cnt == '0) rx_state <= RX_IDLE;
               RX_DIS2:
                  if (strobe) rx_state <= (sym == CMD_OFF) ? RX_DIS3 : RX_IDLE;
                  else if (frame_cnt == '0) rx_state <= RX_IDLE;
               RX_DIS3:
                  if (strobe) begin
                     if (load_req) begin
                        pat_reg  <= PAT_OFF;
                        rx_state <= RX_UPDATE;
                     end else
                        rx_state <= RX_IDLE;
                  end else if (frame_cnt == '0)
                     rx_state <= RX_IDLE;
               RX_UPDATE:
                  if (strobe && dt_ready) begin
                     pat_reg  <= pattern_t'(dt_pend);
                     rx_state <= RX_IDLE;
                  end
               RX_ERROR:
                  if (strobe && sym == CMD_SHUT) rx_state <= RX_CLR1;
               RX_CLR1:
                  if (strobe) rx_state <= (sym == CMD_SHUT) ? RX_CLR2 : RX_ERROR;
                  else if (frame_cnt == '0) rx_state <= RX_ERROR;
               RX_CLR2:
                  if (strobe) begin
                     if (sym == CMD_SHUT) begin
                        flags_reg <= '0;
                        brk_reg   <= 1'b0;
                        rx_state  <= RX_IDLE;
                     end else
                        rx_state <= RX_ERROR;
                  end else if (frame_cnt == '0)
                     rx_state <= RX_ERROR;
               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   assign top       = pat_reg.top;
   assign bot       = pat_reg.bot;
   assign plus      = pat_reg.plus;
   assign minus     = pat_reg.minus;
   assign pause_p   = pat_reg.pause_p;
   assign pause_n   = pat_reg.pause_n;
   assign st        = st_reg;
   assign ch        = ch_reg;
   assign fan       = fan_reg;
   assign brk       = brk_reg;
   assign err_flags = flags_reg;
   assign in_error  = in_error_reg;
   assign idle      = idle_reg;

endmodule

// File: tb/tb_bridge_ctrl.sv
// Scenario bench for bridge_ctrl: expected output snapshots are queued before
// each stimulus and popped for comparison once the DUT has reacted.
module tb_bridge_ctrl;

   localparam logic [11:0] P_OFF   = 12'h000;
   localparam logic [11:0] P_PLUS  = {4'b0001, 4'b0010, 4'b1000};
   localparam logic [11:0] P_MINUS = {4'b0010, 4'b0001, 4'b0100};
   localparam logic [11:0] P_DIS3  = {4'b0100, 4'b1000, 4'b1000};

   logic       clk, rst, bus_clk;
   logic [2:0] bus;
   logic [7:0] err_i;
   logic [3:0] top, bot;
   logic       plus, minus, pause_p, pause_n, st, ch, fan, brk, in_error, idle;
   logic [7:0] err_flags;

   logic [25:0] outv;
   logic [25:0] ex;
   logic [25:0] sb[$];
   int checks = 0;
   int errors = 0;

   assign outv = {top, bot, plus, minus, pause_p, pause_n, st, ch, fan, brk,
                  err_flags, in_error, idle};

   bridge_ctrl #(
      .FREQ(100), .N_ERR(8), .DEADTIME(4), .T_PRECHG_S(2), .T_SETTLE_S(1), .FRAME_TO(50)
   ) dut (
      .clk(clk), .rst(rst), .bus_clk(bus_clk), .bus(bus), .err_i(err_i),
      .top(top), .bot(bot), .plus(plus), .minus(minus), .pause_p(pause_p),
      .pause_n(pause_n), .st(st), .ch(ch), .fan(fan), .brk(brk),
      .err_flags(err_flags), .in_error(in_error), .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [25:0] mk(input logic [11:0] pat, input logic s, c, f, b,
                                      input logic [7:0] fl, input logic ie, id);
      return {pat, s, c, f, b, fl, ie, id};
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One strobe: high for one edge, falling edge sampled on the next.
   task automatic send_sym(input logic [2:0] s);
      bus = s;
      bus_clk = 1'b1;
      @(posedge clk); #1;
      bus_clk = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sb.push_back(26'h0);
      wait_clk(3);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL reset_hold: got %h want %h", outv, ex); end
      rst = 1'b0;
      sb.push_back(mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
      wait_clk(2);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL reset_idle: got %h want %h", outv, ex); end
   endtask

   task automatic test_start();
      send_sym(3'd5);
      sb.push_back(mk(P_OFF, 0, 1, 1, 0, 8'h00, 0, 1));
      send_sym(3'd0);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL start_charge: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 0, 1, 1, 0, 8'h00, 0, 1));
      wait_clk(197);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL start_pre_wait: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 1, 1, 1, 0, 8'h00, 0, 1));
      wait_clk(4);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL start_st_on: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 1, 1, 1, 0, 8'h00, 0, 1));
      wait_clk(96);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL start_settle: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 1, 0, 1, 0, 8'h00, 0, 1));
      wait_clk(4);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL start_ch_off: got %h want %h", outv, ex); end
   endtask

   task automatic test_pattern();
      sb.push_back(mk(P_OFF, 1, 0, 1, 0, 8'h00, 0, 0));
      send_sym(3'd1);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL plus_load_off: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 1, 0, 1, 0, 8'h00, 0, 0));
      send_sym(3'd0);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL early_strobe_ignored: got %h want %h", outv, ex); end
      wait_clk(4);
      sb.push_back(mk(P_PLUS, 1, 0, 1, 0, 8'h00, 0, 1));
      send_sym(3'd0);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL plus_apply: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 1, 0, 1, 0, 8'h00, 0, 0));
      send_sym(3'd2);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL minus_load_off: got %h want %h", outv, ex); end
      wait_clk(4);
      sb.push_back(mk(P_MINUS, 1, 0, 1, 0, 8'h00, 0, 1));
      send_sym(3'd0);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL minus_apply: got %h want %h", outv, ex); end
   endtask

   task automatic test_idle_ignore();
      sb.push_back(mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
      send_sym(3'd6);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL shutdown: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
      send_sym(3'd1);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL plus_without_st: got %h want %h", outv, ex); end
   endtask

   task automatic test_discharge();
      send_sym(3'd7); send_sym(3'd0); send_sym(3'd7); send_sym(3'd0); send_sym(3'd3);
      wait_clk(4);
      sb.push_back(mk(P_DIS3, 0, 0, 0, 0, 8'h00, 0, 1));
      send_sym(3'd0);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL dis3_apply: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
      send_sym(3'd0);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL sym0_off: got %h want %h", outv, ex); end
      send_sym(3'd7);
      sb.push_back(mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 0));
      send_sym(3'd0);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL in_frame: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
      wait_clk(60);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL frame_timeout: got %h want %h", outv, ex); end
   endtask

   task automatic test_error();
      send_sym(3'd5); send_sym(3'd0);
      wait_clk(305);
      send_sym(3'd1);
      wait_clk(4);
      sb.push_back(mk(P_PLUS, 1, 0, 1, 0, 8'h00, 0, 1));
      send_sym(3'd0);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL err_setup_plus: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 0, 0, 1, 1, 8'h20, 1, 0));
      err_i = 8'h20;
      @(posedge clk); #1;
      err_i = 8'h00;
      wait_clk(1);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL err_trip: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 0, 0, 1, 0, 8'h00, 0, 1));
      send_sym(3'd6); send_sym(3'd6); send_sym(3'd6);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL err_clear: got %h want %h", outv, ex); end
   endtask

   task automatic test_clear_blocked();
      err_i = 8'h01;
      wait_clk(2);
      sb.push_back(mk(P_OFF, 0, 0, 1, 1, 8'h01, 1, 0));
      send_sym(3'd6); send_sym(3'd6); send_sym(3'd6);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL clear_blocked: got %h want %h", outv, ex); end
      err_i = 8'h00;
      sb.push_back(mk(P_OFF, 0, 0, 1, 1, 8'h01, 1, 0));
      send_sym(3'd6); send_sym(3'd1);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL clear_abort: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 0, 0, 1, 1, 8'h09, 1, 0));
      err_i = 8'h08;
      @(posedge clk); #1;
      err_i = 8'h00;
      wait_clk(1);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL flags_sticky: got %h want %h", outv, ex); end
      sb.push_back(mk(P_OFF, 0, 0, 1, 0, 8'h00, 0, 1));
      send_sym(3'd6); send_sym(3'd6); send_sym(3'd6);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL clear_after_drop: got %h want %h", outv, ex); end
   endtask

   task automatic test_async_reset();
      send_sym(3'd5); send_sym(3'd0);
      wait_clk(10);
      sb.push_back(26'h0);
      #2 rst = 1'b1;
      #1;
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL async_reset: got %h want %h", outv, ex); end
      @(posedge clk); #1;
      rst = 1'b0;
      sb.push_back(mk(P_OFF, 0, 0, 0, 0, 8'h00, 0, 1));
      wait_clk(2);
      ex = sb.pop_front(); checks++;
      if (outv !== ex) begin errors++; $display("FAIL post_reset_idle: got %h want %h", outv, ex); end
   endtask

   initial begin
      rst = 1'b0;
      bus_clk = 1'b0;
      bus = 3'd0;
      err_i = 8'h00;
      #2;
      test_reset();
      test_start();
      test_pattern();
      test_idle_ignore();
      test_discharge();
      test_error();
      test_clear_blocked();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
